// File: rtl/mem_write_checker_if.sv
// Data-memory write port of a MIPS core, as seen by mem_write_checker.
//   memwrite   : write enable
//   dataadr    : write address (WIDTH bits)
//   writedata  : write data    (WIDTH bits)
// master: the core (or a bench) driving the port; slave: the checker.
interface mem_write_checker_if #(
  parameter int WIDTH = 32
) ();
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker.sv
// mem_write_checker: self-check monitor for the MIPS cores' data-memory
// write port. Matches writes in order against a loadable table of expected
// (address, data) pairs, skips a scratch address window, and reports
// pass / fail / timeout so simulation benches and FPGA builds share one checker.
//
// Ports:
//   clk, reset      : clock (rising edge) and synchronous active-high reset
//   start           : begin checking (accepted when not busy)
//   exp_we/exp_idx/exp_adr/exp_data : expected-table write port (not in RUN)
//   exp_count       : valid table entries, sampled on start (clamped to DEPTH)
//   mem             : watched write port (memwrite, dataadr, writedata)
//   busy/pass/fail/timeout : registered status
//   matched         : expected writes matched so far
//   fail_idx        : table index pending when fail asserted
//   bad_adr/bad_data: address/data of the failing write (CHK_CAPTURE_EN only)
//
// Build option: define CHK_CAPTURE_EN to add the bad_adr/bad_data capture.
module mem_write_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int IGN_LO  = 80,
  parameter int IGN_HI  = 80,
  parameter int TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_idx,
  input  logic [WIDTH-1:0]         exp_adr,
  input  logic [WIDTH-1:0]         exp_data,
  input  logic [$clog2(DEPTH):0]   exp_count,
  mem_write_checker_if.slave       mem,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   matched,
  output logic [$clog2(DEPTH)-1:0] fail_idx
`ifdef CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]         bad_adr,
  output logic [WIDTH-1:0]         bad_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMAX     = TW'(TIMEOUT - 1);
  localparam logic             IGN_EN   = (IGN_HI >= IGN_LO);
  localparam logic [WIDTH-1:0] IGN_LO_W = WIDTH'(IGN_LO);
  localparam logic [WIDTH-1:0] IGN_HI_W = WIDTH'(IGN_HI);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TOUT
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   matched_q, matched_d;
  logic [AW-1:0]   fail_idx_q, fail_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_q, pass_q, fail_q, timeout_q;
`ifdef CHK_CAPTURE_EN
  logic [WIDTH-1:0] bad_adr_q, bad_adr_d;
  logic [WIDTH-1:0] bad_data_q, bad_data_d;
`endif

  // Expected-write table; contents deliberately survive reset.
  logic [WIDTH-1:0] adr_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic            in_ign;
  logic            hit;
  logic            last;
  logic [CW-1:0]   cnt_start;

  always_ff @(posedge clk) begin
    if (exp_we && (state_q != S_RUN)) begin
      adr_q[exp_idx]  <= exp_adr;
      data_q[exp_idx] <= exp_data;
    end
  end

  assign in_ign    = IGN_EN && (mem.dataadr >= IGN_LO_W) && (mem.dataadr <= IGN_HI_W);
  assign hit       = (mem.dataadr == adr_q[ptr_q]) && (mem.writedata == data_q[ptr_q]);
  assign last      = ({1'b0, ptr_q} == (cnt_q - CW'(1)));
  assign cnt_start = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    matched_d  = matched_q;
    fail_idx_d = fail_idx_q;
    timer_d    = timer_q;
`ifdef CHK_CAPTURE_EN
    bad_adr_d  = bad_adr_q;
    bad_data_d = bad_data_q;
`endif
    case (state_q)
      S_RUN: begin
        timer_d = timer_q + TW'(1);
        if (mem.memwrite && !in_ign) begin
          if (hit) begin
            ptr_d     = ptr_q + AW'(1);
            matched_d = matched_q + CW'(1);
            if (last) state_d = S_PASS;
          end else begin
            state_d    = S_FAIL;
            fail_idx_d = ptr_q;
`ifdef CHK_CAPTURE_EN
            bad_adr_d  = mem.dataadr;
            bad_data_d = mem.writedata;
`endif
          end
        end
        // A terminal write on the expiry cycle takes precedence over timeout.
        if ((state_d == S_RUN) && (timer_q == TMAX)) state_d = S_TOUT;
      end
      default: begin
        if (start) begin
          ptr_d      = '0;
          matched_d  = '0;
          fail_idx_d = '0;
          timer_d    = '0;
          cnt_d      = cnt_start;
`ifdef CHK_CAPTURE_EN
          bad_adr_d  = '0;
          bad_data_d = '0;
`endif
          state_d    = (cnt_start == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      matched_q  <= '0;
      fail_idx_q <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef CHK_CAPTURE_EN
      bad_adr_q  <= '0;
      bad_data_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      matched_q  <= matched_d;
      fail_idx_q <= fail_idx_d;
      timer_q    <= timer_d;
      busy_q     <= (state_d == S_RUN);
      pass_q     <= (state_d == S_PASS);
      fail_q     <= (state_d == S_FAIL);
      timeout_q  <= (state_d == S_TOUT);
`ifdef CHK_CAPTURE_EN
      bad_adr_q  <= bad_adr_d;
      bad_data_q <= bad_data_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign matched  = matched_q;
  assign fail_idx = fail_idx_q;
`ifdef CHK_CAPTURE_EN
  assign bad_adr  = bad_adr_q;
  assign bad_data = bad_data_q;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed vector table, hand-written multi-cycle
// sequences (timeout, reset abort, clamped count) and randomized runs compared
// cycle by cycle against a trace-scanning reference model.
module tb_mem_write_checker;
  localparam int TO = 20;
  localparam logic [31:0] Z0 = 32'd0;

  logic        clk = 1'b0;
  logic        reset, start, exp_we;
  logic [2:0]  exp_idx;
  logic [31:0] exp_adr, exp_data;
  logic [3:0]  exp_count;
  logic        busy, pass, fail, timeout;
  logic [3:0]  matched;
  logic [2:0]  fail_idx;
`ifdef CHK_CAPTURE_EN
  logic [31:0] bad_adr, bad_data;
`endif

  int total = 0;
  int n_bad = 0;

  mem_write_checker_if #(.WIDTH(32)) bus ();

  mem_write_checker #(
    .WIDTH(32), .DEPTH(8), .IGN_LO(80), .IGN_HI(80), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we),
    .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .exp_count(exp_count), .mem(bus),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .matched(matched), .fail_idx(fail_idx)
`ifdef CHK_CAPTURE_EN
    , .bad_adr(bad_adr), .bad_data(bad_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int               nt;
    logic [3:0][31:0] ta;
    logic [3:0][31:0] td;
    int               cnt;
    int               nw;
    logic [3:0][31:0] wa;
    logic [3:0][31:0] wd;
    logic             e_busy, e_pass, e_fail, e_tout;
    int               e_m, e_fi;
    logic [31:0]      e_ba, e_bd;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [10:0] pack(bit b, bit p, bit f, bit t, int m, int fi);
    return {b, p, f, t, 4'(m), 3'(fi)};
  endfunction

  function automatic logic [10:0] outs();
    return {busy, pass, fail, timeout, matched, fail_idx};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; exp_we = 1'b0;
    bus.memwrite = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = 3'(idx); exp_adr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic begin_run(input int cnt);
    exp_count = 4'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
    tick();
    bus.memwrite = 1'b0;
  endtask

  function automatic logic [31:0] pick_adr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 3) return 32'd4;
    if (s < 5) return 32'd8;
    if (s < 7) return 32'd12;
    if (s < 8) return 32'd84;
    if (s < 9) return 32'd16;
    return 32'd80;
  endfunction

  // Random-run state (model side and stimulus side)
  logic [31:0] ma[8], md[8];
  int ec, mcnt, k, mfi, sp;
  bit done, mp, mf, mt, we;
  logic [31:0] a, d, mba, mbd;

  initial begin
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
    exp_idx = '0; exp_adr = '0; exp_data = '0; exp_count = '0;
    reset = 1'b1; start = 1'b0; exp_we = 1'b0;

    //            nt  table addr              table data                        cnt nw  write addr                    write data                        b     p     f     t    m  fi  bad_adr bad_data
    vecs[0] = '{1, {Z0,Z0,Z0,32'd84}, {Z0,Z0,Z0,32'hFFFFFFFC},               1, 2, {Z0,Z0,32'd84,32'd80},       {Z0,Z0,32'hFFFFFFFC,32'd7},  1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 32'd0,  32'd0};
    vecs[1] = '{1, {Z0,Z0,Z0,32'd84}, {Z0,Z0,Z0,32'hFFFFFFFC},               1, 1, {Z0,Z0,Z0,32'd88},           {Z0,Z0,Z0,32'd5},            1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'd88, 32'd5};
    vecs[2] = '{3, {Z0,32'd12,32'd8,32'd4}, {Z0,32'd3,32'd2,32'd1},          3, 2, {Z0,Z0,32'd12,32'd4},        {Z0,Z0,32'd3,32'd1},         1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 32'd12, 32'd3};
    vecs[3] = '{3, {Z0,32'd12,32'd8,32'd4}, {Z0,32'd3,32'd2,32'd1},          3, 3, {Z0,32'd12,32'd8,32'd4},     {Z0,32'd3,32'd2,32'd1},      1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 32'd0,  32'd0};
    vecs[4] = '{0, {Z0,Z0,Z0,Z0}, {Z0,Z0,Z0,Z0},                              0, 0, {Z0,Z0,Z0,Z0},               {Z0,Z0,Z0,Z0},               1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'd0,  32'd0};
    vecs[5] = '{1, {Z0,Z0,Z0,32'd80}, {Z0,Z0,Z0,32'd9},                       1, 1, {Z0,Z0,Z0,32'd80},           {Z0,Z0,Z0,32'd9},            1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0,  32'd0};
    vecs[6] = '{1, {Z0,Z0,Z0,32'd4}, {Z0,Z0,Z0,32'd1},                        1, 1, {Z0,Z0,Z0,32'd4},            {Z0,Z0,Z0,32'd2},            1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'd4,  32'd2};
    vecs[7] = '{3, {Z0,32'd12,32'd8,32'd4}, {Z0,32'd3,32'd2,32'd1},          3, 3, {Z0,32'd12,32'd8,32'd4},     {Z0,32'd4,32'd2,32'd1},      1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 32'd12, 32'd4};

    // Reset state
    do_reset();
    chk("reset_outs", 64'(outs()), 64'(pack(0, 0, 0, 0, 0, 0)));
`ifdef CHK_CAPTURE_EN
    chk("reset_bad_adr", bad_adr, 0);
    chk("reset_bad_data", bad_data, 0);
`endif

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int e = 0; e < vecs[v].nt; e++) load(e, vecs[v].ta[e], vecs[v].td[e]);
      begin_run(vecs[v].cnt);
      for (int w = 0; w < vecs[v].nw; w++) wr(vecs[v].wa[w], vecs[v].wd[w]);
      chk($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
      chk($sformatf("vec%0d_pass", v), pass, vecs[v].e_pass);
      chk($sformatf("vec%0d_fail", v), fail, vecs[v].e_fail);
      chk($sformatf("vec%0d_timeout", v), timeout, vecs[v].e_tout);
      chk($sformatf("vec%0d_matched", v), matched, 64'(vecs[v].e_m));
      chk($sformatf("vec%0d_fail_idx", v), fail_idx, 64'(vecs[v].e_fi));
`ifdef CHK_CAPTURE_EN
      chk($sformatf("vec%0d_bad_adr", v), bad_adr, vecs[v].e_ba);
      chk($sformatf("vec%0d_bad_data", v), bad_data, vecs[v].e_bd);
`endif
    end

    // Timeout after exactly TO RUN cycles, then a matching write on the expiry cycle
    do_reset();
    load(0, 32'd4, 32'd1);
    begin_run(1);
    repeat (TO - 1) tick();
    chk("tout_before", 64'(outs()), 64'(pack(1, 0, 0, 0, 0, 0)));
    tick();
    chk("tout_expired", 64'(outs()), 64'(pack(0, 0, 0, 1, 0, 0)));
    begin_run(1);
    chk("tout_restart", 64'(outs()), 64'(pack(1, 0, 0, 0, 0, 0)));
    repeat (TO - 1) tick();
    wr(32'd4, 32'd1);
    chk("tout_write_wins", 64'(outs()), 64'(pack(0, 1, 0, 0, 1, 0)));

    // Reset mid-RUN, table kept; table writes and start ignored in RUN; sticky PASS
    do_reset();
    load(0, 32'd4, 32'd1); load(1, 32'd8, 32'd2); load(2, 32'd12, 32'd3);
    begin_run(3);
    wr(32'd4, 32'd1);
    chk("abort_one_match", 64'(outs()), 64'(pack(1, 0, 0, 0, 1, 0)));
    load(1, 32'd99, 32'd99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_outs", 64'(outs()), 64'(pack(0, 0, 0, 0, 0, 0)));
    begin_run(3);
    wr(32'd4, 32'd1);
    begin_run(3);
    chk("start_in_run", 64'(outs()), 64'(pack(1, 0, 0, 0, 1, 0)));
    wr(32'd8, 32'd2);
    wr(32'd12, 32'd3);
    chk("rerun_pass", 64'(outs()), 64'(pack(0, 1, 0, 0, 3, 0)));
    wr(32'd88, 32'd5);
    chk("pass_sticky", 64'(outs()), 64'(pack(0, 1, 0, 0, 3, 0)));

    // exp_count above DEPTH is clamped
    do_reset();
    for (int e = 0; e < 8; e++) load(e, 32'(4 * (e + 1)), 32'(e + 10));
    begin_run(11);
    for (int e = 0; e < 7; e++) wr(32'(4 * (e + 1)), 32'(e + 10));
    chk("clamp_seven", 64'(outs()), 64'(pack(1, 0, 0, 0, 7, 0)));
    wr(32'd32, 32'd17);
    chk("clamp_pass", 64'(outs()), 64'(pack(0, 1, 0, 0, 8, 0)));

    // Randomized runs against the reference model
    for (int r = 0; r < 60; r++) begin
      do_reset();
      for (int e = 0; e < 8; e++) begin
        ma[e] = pick_adr();
        md[e] = 32'($urandom_range(0, 3));
        load(e, ma[e], md[e]);
      end
      ec   = $urandom_range(0, 11);
      mcnt = (ec > 8) ? 8 : ec;
      begin_run(ec);
      k = 0; mfi = 0; sp = 0; mba = '0; mbd = '0;
      done = (mcnt == 0); mp = done; mf = 1'b0; mt = 1'b0;
      chk("rand_start", 64'(outs()), 64'(pack(!done, mp, mf, mt, k, mfi)));
      for (int c = 0; c < TO + 2; c++) begin
        we = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 99)) inside
          [0:69]:  begin a = ma[sp % 8]; d = md[sp % 8]; sp++; end
          [70:84]: begin a = 32'd80; d = 32'($urandom_range(0, 3)); end
          default: begin a = pick_adr(); d = 32'($urandom_range(0, 3)); end
        endcase
        bus.memwrite = we; bus.dataadr = a; bus.writedata = d;
        tick();
        bus.memwrite = 1'b0;
        if (!done) begin
          if (we && !(a >= 80 && a <= 80)) begin
            if (a == ma[k] && d == md[k]) begin
              k++;
              if (k == mcnt) begin done = 1'b1; mp = 1'b1; end
            end else begin
              done = 1'b1; mf = 1'b1; mfi = k; mba = a; mbd = d;
            end
          end
          if (!done && c == TO - 1) begin done = 1'b1; mt = 1'b1; end
        end
        chk($sformatf("rand%0d_cycle%0d", r, c), 64'(outs()), 64'(pack(!done, mp, mf, mt, k, mfi)));
      end
`ifdef CHK_CAPTURE_EN
      chk($sformatf("rand%0d_bad_adr", r), bad_adr, mba);
      chk($sformatf("rand%0d_bad_data", r), bad_data, mbd);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
